// File: rtl/mm_game_pkg.sv
// mm_game_pkg: shared types and constants for the game sequencing controller.
//   state_e    - controller FSM states
//   CTRL_*     - counter move codes (move_ctrl / cnt_ctrl encoding)
//   COUNT_*    - counter values with game meaning
//   fix_seed   - maps the degenerate seeds 0 and 15 onto the counter reset value
//   sat_inc4   - 4-bit increment that sticks at 15
package mm_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_MOVE = 3'd2,
        S_STEP      = 3'd3,
        S_CHECK     = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    localparam logic [1:0] CTRL_UP1 = 2'b00;
    localparam logic [1:0] CTRL_UP2 = 2'b01;
    localparam logic [1:0] CTRL_DN1 = 2'b10;
    localparam logic [1:0] CTRL_DN2 = 2'b11;

    localparam logic [3:0] COUNT_WIN  = 4'hF;
    localparam logic [3:0] COUNT_LOSE = 4'h0;
    localparam logic [3:0] COUNT_RST  = 4'h7;

    // A seed already sitting on a terminal value would end the round
    // before any move, so it is replaced by the mid-range reset value.
    function automatic logic [3:0] fix_seed(input logic [3:0] s);
        return (s == COUNT_LOSE || s == COUNT_WIN) ? COUNT_RST : s;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mm_game_ctrl_if.sv
// mm_game_ctrl_if: player/stimulus, counter and score signals of the game
// controller.
//   master - player side plus the counter (drives start/seed/move/count)
//   slave  - the controller (drives move_ready, counter controls, scores)
interface mm_game_ctrl_if;
    logic       start;
    logic [3:0] seed;
    logic       move_valid;
    logic [1:0] move_ctrl;
    logic       move_ready;
    logic [3:0] count;
    logic       cnt_init;
    logic [3:0] cnt_inval;
    logic [1:0] cnt_ctrl;
    logic [3:0] win_cnt;
    logic [3:0] loss_cnt;
    logic       round_win;
    logic       round_loss;
    logic       game_over;
    logic       player_won;

    modport master (
        output start, seed, move_valid, move_ctrl, count,
        input  move_ready, cnt_init, cnt_inval, cnt_ctrl, win_cnt, loss_cnt,
               round_win, round_loss, game_over, player_won
    );

    modport slave (
        input  start, seed, move_valid, move_ctrl, count,
        output move_ready, cnt_init, cnt_inval, cnt_ctrl, win_cnt, loss_cnt,
               round_win, round_loss, game_over, player_won
    );
endinterface

// File: rtl/mm_game_score.sv
// mm_game_score: game score keeping.
//   clk_i, rst_ni      - clock, async active-low reset
//   clr_i              - clear both scores (new game)
//   win_stb_i          - round won this cycle
//   loss_stb_i         - round lost this cycle
//   done_i             - controller is in DONE
//   win_cnt_o/loss_cnt_o   - saturating round counters
//   round_win_o/round_loss_o - registered one-cycle round pulses
//   win_hit_o/loss_hit_o   - this strobe makes its counter reach the target
//   player_won_o       - game ended on the win target
module mm_game_score
    import mm_game_pkg::*;
#(
    parameter int WIN_TARGET  = 3,
    parameter int LOSS_TARGET = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       win_stb_i,
    input  logic       loss_stb_i,
    input  logic       done_i,
    output logic [3:0] win_cnt_o,
    output logic [3:0] loss_cnt_o,
    output logic       round_win_o,
    output logic       round_loss_o,
    output logic       win_hit_o,
    output logic       loss_hit_o,
    output logic       player_won_o
);
    localparam logic [3:0] WIN_T  = 4'(WIN_TARGET);
    localparam logic [3:0] LOSS_T = 4'(LOSS_TARGET);

    logic [3:0] win_q, win_d, loss_q, loss_d;
    logic       rw_q, rl_q;

    always_comb begin
        win_d  = win_q;
        loss_d = loss_q;
        if (clr_i) begin
            win_d  = 4'd0;
            loss_d = 4'd0;
        end else begin
            if (win_stb_i)  win_d  = sat_inc4(win_q);
            if (loss_stb_i) loss_d = sat_inc4(loss_q);
        end
    end

    // Target compare on the post-increment value so CHECK can branch to
    // DONE in the same cycle the deciding round is judged.
    assign win_hit_o  = win_stb_i  && (sat_inc4(win_q)  >= WIN_T);
    assign loss_hit_o = loss_stb_i && (sat_inc4(loss_q) >= LOSS_T);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q  <= 4'd0;
            loss_q <= 4'd0;
            rw_q   <= 1'b0;
            rl_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            loss_q <= loss_d;
            rw_q   <= win_stb_i;
            rl_q   <= loss_stb_i;
        end
    end

    assign win_cnt_o    = win_q;
    assign loss_cnt_o   = loss_q;
    assign round_win_o  = rw_q;
    assign round_loss_o = rl_q;
    assign player_won_o = done_i && (win_q >= WIN_T);
endmodule

// File: rtl/mm_game_ctrl.sv
// mm_game_ctrl: sequencing controller for the multi-mode 4-bit game counter.
// Loads the round seed, lets the counter step once per accepted move, judges
// the result (15 win, 0 loss), keeps score and declares game over.
//   dclk, arstn - clock, async active-low reset
//   bus         - mm_game_ctrl_if.slave: start/seed, move handshake, counter
//                 INIT/inval/ctrl + count feedback, scores and game status
// Build option: MM_GAME_TIMEOUT_EN adds a per-round move counter; a round that
// reaches MAX_MOVES moves without 0/15 is scored as a loss.
module mm_game_ctrl
    import mm_game_pkg::*;
#(
    parameter int WIN_TARGET  = 3,
    parameter int LOSS_TARGET = 3,
    parameter int MAX_MOVES   = 8
) (
    input  logic          dclk,
    input  logic          arstn,
    mm_game_ctrl_if.slave bus
);
    state_e     state_q, state_d;
    logic [3:0] seed_q, seed_d;
    logic [1:0] mv_q, mv_d;
    logic       start_ok, is_win, is_lose, timeout;
    logic       win_stb, loss_stb, win_hit, loss_hit;

    assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_win   = (bus.count == COUNT_WIN);
    assign is_lose  = (bus.count == COUNT_LOSE);

`ifdef MM_GAME_TIMEOUT_EN
    logic [7:0] mcnt_q, mcnt_d;

    assign timeout = (state_q == S_CHECK) && !is_win && !is_lose
                     && (mcnt_q + 8'd1 == 8'(MAX_MOVES));

    always_comb begin
        mcnt_d = mcnt_q;
        if (state_q == S_LOAD)
            mcnt_d = 8'd0;
        else if (state_q == S_CHECK && !is_win && !is_lose)
            mcnt_d = mcnt_q + 8'd1;
    end

    always_ff @(posedge dclk or negedge arstn) begin
        if (!arstn) mcnt_q <= 8'd0;
        else        mcnt_q <= mcnt_d;
    end
`else
    logic unused_max_moves;
    assign unused_max_moves = |8'(MAX_MOVES);
    assign timeout = 1'b0;
`endif

    assign win_stb  = (state_q == S_CHECK) && is_win;
    assign loss_stb = (state_q == S_CHECK) && (is_lose || timeout);

    always_comb begin
        state_d = state_q;
        seed_d  = start_ok ? fix_seed(bus.seed) : seed_q;
        mv_d    = mv_q;
        unique case (state_q)
            S_IDLE:      if (bus.start) state_d = S_LOAD;
            S_LOAD:      state_d = S_WAIT_MOVE;
            S_WAIT_MOVE: if (bus.move_valid) begin
                             mv_d    = bus.move_ctrl;
                             state_d = S_STEP;
                         end
            S_STEP:      state_d = S_CHECK;
            S_CHECK:     if (win_stb || loss_stb)
                             state_d = (win_hit || loss_hit) ? S_DONE : S_LOAD;
                         else
                             state_d = S_WAIT_MOVE;
            S_DONE:      if (bus.start) state_d = S_LOAD;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            seed_q  <= COUNT_RST;
            mv_q    <= CTRL_UP1;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            mv_q    <= mv_d;
        end
    end

    // Outside LOAD/STEP the counter is held by reloading its own value.
    assign bus.cnt_init   = (state_q != S_STEP);
    assign bus.cnt_inval  = (state_q == S_LOAD) ? seed_q : bus.count;
    assign bus.cnt_ctrl   = (state_q == S_STEP) ? mv_q : CTRL_UP1;
    assign bus.move_ready = (state_q == S_WAIT_MOVE);
    assign bus.game_over  = (state_q == S_DONE);

    mm_game_score #(
        .WIN_TARGET (WIN_TARGET),
        .LOSS_TARGET(LOSS_TARGET)
    ) u_score (
        .clk_i       (dclk),
        .rst_ni      (arstn),
        .clr_i       (start_ok),
        .win_stb_i   (win_stb),
        .loss_stb_i  (loss_stb),
        .done_i      (state_q == S_DONE),
        .win_cnt_o   (bus.win_cnt),
        .loss_cnt_o  (bus.loss_cnt),
        .round_win_o (bus.round_win),
        .round_loss_o(bus.round_loss),
        .win_hit_o   (win_hit),
        .loss_hit_o  (loss_hit),
        .player_won_o(bus.player_won)
    );
endmodule

// File: tb/tb_mm_game_ctrl.sv
// Bench for mm_game_ctrl with WIN_TARGET=2, LOSS_TARGET=3, MAX_MOVES=4 and a
// behavioural model of the 4-bit counter closing the count loop.
module tb_mm_game_ctrl;
    import mm_game_pkg::*;

    logic dclk  = 1'b0;
    logic arstn = 1'b0;
    always #5 dclk = ~dclk;

    mm_game_ctrl_if bus ();

    mm_game_ctrl #(
        .WIN_TARGET (2),
        .LOSS_TARGET(3),
        .MAX_MOVES  (4)
    ) dut (
        .dclk (dclk),
        .arstn(arstn),
        .bus  (bus)
    );

    // Counter being sequenced: INIT loads, otherwise steps by mode.
    always_ff @(posedge dclk or negedge arstn) begin
        if (!arstn)            bus.count <= COUNT_RST;
        else if (bus.cnt_init) bus.count <= bus.cnt_inval;
        else case (bus.cnt_ctrl)
            CTRL_UP1: bus.count <= bus.count + 4'd1;
            CTRL_UP2: bus.count <= bus.count + 4'd2;
            CTRL_DN1: bus.count <= bus.count - 4'd1;
            default:  bus.count <= bus.count - 4'd2;
        endcase
    end

    typedef struct packed {
        logic       rw;
        logic       rl;
        logic [3:0] wc;
        logic [3:0] lc;
    } evt_t;

    evt_t       evq[$];
    logic [3:0] cntq[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, hs_cyc = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge dclk);
            #1;
            cyc++;
            if (arstn) begin
                if (bus.move_valid && bus.move_ready) begin
                    hs_cyc = cyc;
                    if (cntq.size() == 0) chk("unexpected_handshake", 8'd1, 8'd0);
                    else                  chk("count_at_handshake", {4'd0, bus.count}, {4'd0, cntq.pop_front()});
                end
                if (bus.round_win || bus.round_loss) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_round_pulse", {6'd0, bus.round_win, bus.round_loss}, 8'd0);
                    end else begin
                        e = evq.pop_front();
                        chk("round_win",  {7'd0, bus.round_win},  {7'd0, e.rw});
                        chk("round_loss", {7'd0, bus.round_loss}, {7'd0, e.rl});
                        chk("win_cnt",    {4'd0, bus.win_cnt},    {4'd0, e.wc});
                        chk("loss_cnt",   {4'd0, bus.loss_cnt},   {4'd0, e.lc});
                        chk("pulse_latency", 8'(cyc - hs_cyc), 8'd3);
                    end
                end
            end
        end
    end

    task automatic start_game(input logic [3:0] s);
        @(negedge dclk);
        bus.start = 1'b1;
        bus.seed  = s;
        @(negedge dclk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.move_ready && t < 20) begin
            @(negedge dclk);
            t++;
        end
        if (!bus.move_ready) chk("move_ready_timeout", 8'd0, 8'd1);
    endtask

    task automatic move(input logic [1:0] c, input logic [3:0] hs_cnt, input bit ev,
                        input bit rw, input bit rl, input logic [3:0] wc, input logic [3:0] lc);
        cntq.push_back(hs_cnt);
        if (ev) evq.push_back('{rw, rl, wc, lc});
        @(negedge dclk);
        bus.move_valid = 1'b1;
        bus.move_ctrl  = c;
        wait_ready();
        @(negedge dclk);
        bus.move_valid = 1'b0;
        repeat (4) @(negedge dclk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bus.start      = 1'b0;
        bus.seed       = 4'd0;
        bus.move_valid = 1'b0;
        bus.move_ctrl  = 2'b00;

        // Reset state
        repeat (2) @(negedge dclk);
        #2;
        chk("rst_cnt_init",   {7'd0, bus.cnt_init},   8'd1);
        chk("rst_cnt_inval",  {4'd0, bus.cnt_inval},  8'd7);
        chk("rst_cnt_ctrl",   {6'd0, bus.cnt_ctrl},   8'd0);
        chk("rst_move_ready", {7'd0, bus.move_ready}, 8'd0);
        chk("rst_win_cnt",    {4'd0, bus.win_cnt},    8'd0);
        chk("rst_loss_cnt",   {4'd0, bus.loss_cnt},   8'd0);
        chk("rst_game_over",  {7'd0, bus.game_over},  8'd0);
        chk("rst_player_won", {7'd0, bus.player_won}, 8'd0);
        @(negedge dclk);
        arstn = 1'b1;

        // Game A: two wins from seed 13 end the game
        start_game(4'd13);
        #2;
        chk("load_cnt_init",  {7'd0, bus.cnt_init},  8'd1);
        chk("load_cnt_inval", {4'd0, bus.cnt_inval}, 8'd13);
        move(CTRL_UP2, 4'd13, 1, 1, 0, 4'd1, 4'd0);
        move(CTRL_UP2, 4'd13, 1, 1, 0, 4'd2, 4'd0);
        #2;
        chk("done_game_over",  {7'd0, bus.game_over},  8'd1);
        chk("done_player_won", {7'd0, bus.player_won}, 8'd1);
        chk("done_move_ready", {7'd0, bus.move_ready}, 8'd0);
        chk("done_win_cnt",    {4'd0, bus.win_cnt},    8'd2);

        // Game B: restart from DONE clears scores; wrap-around judging
        start_game(4'd1);
        #2;
        chk("restart_win_cnt",   {4'd0, bus.win_cnt},   8'd0);
        chk("restart_loss_cnt",  {4'd0, bus.loss_cnt},  8'd0);
        chk("restart_game_over", {7'd0, bus.game_over}, 8'd0);
        chk("restart_inval",     {4'd0, bus.cnt_inval}, 8'd1);
        move(CTRL_DN2, 4'd1, 1, 1, 0, 4'd1, 4'd0);  // 1-2 wraps to 15: win
        move(CTRL_DN1, 4'd1, 1, 0, 1, 4'd1, 4'd1);  // 1-1 = 0: loss

        // start while waiting for a move is ignored
        @(negedge dclk);
        bus.start = 1'b1;
        bus.seed  = 4'd14;
        @(negedge dclk);
        bus.start = 1'b0;

        // Reset asserted during STEP
        cntq.push_back(4'd1);
        @(negedge dclk);
        bus.move_valid = 1'b1;
        bus.move_ctrl  = CTRL_UP1;
        wait_ready();
        @(posedge dclk);
        #2;
        arstn = 1'b0;
        bus.move_valid = 1'b0;
        #1;
        chk("mid_rst_cnt_init",   {7'd0, bus.cnt_init},   8'd1);
        chk("mid_rst_cnt_inval",  {4'd0, bus.cnt_inval},  8'd7);
        chk("mid_rst_move_ready", {7'd0, bus.move_ready}, 8'd0);
        chk("mid_rst_win_cnt",    {4'd0, bus.win_cnt},    8'd0);
        chk("mid_rst_loss_cnt",   {4'd0, bus.loss_cnt},   8'd0);
        @(negedge dclk);
        @(negedge dclk);
        arstn = 1'b1;
        repeat (3) @(negedge dclk);
        #2;
        chk("idle_after_rst_ready", {7'd0, bus.move_ready}, 8'd0);
        chk("idle_after_rst_count", {4'd0, bus.count},      8'd7);

        // Game C: three losses from seed 14 (14+2 wraps to 0)
        start_game(4'd14);
        move(CTRL_UP2, 4'd14, 1, 0, 1, 4'd0, 4'd1);
        move(CTRL_UP2, 4'd14, 1, 0, 1, 4'd0, 4'd2);
        move(CTRL_UP2, 4'd14, 1, 0, 1, 4'd0, 4'd3);
        #2;
        chk("lost_game_over",  {7'd0, bus.game_over},  8'd1);
        chk("lost_player_won", {7'd0, bus.player_won}, 8'd0);
        chk("lost_loss_cnt",   {4'd0, bus.loss_cnt},   8'd3);

        // Seed 0 loads 7; four non-terminal moves exercise the move limit
        start_game(4'd0);
        #2;
        chk("seed0_inval", {4'd0, bus.cnt_inval}, 8'd7);
        move(CTRL_UP1, 4'd7, 0, 0, 0, 4'd0, 4'd0);
        move(CTRL_DN1, 4'd8, 0, 0, 0, 4'd0, 4'd0);
        move(CTRL_UP1, 4'd7, 0, 0, 0, 4'd0, 4'd0);
`ifdef MM_GAME_TIMEOUT_EN
        move(CTRL_DN1, 4'd8, 1, 0, 1, 4'd0, 4'd1);
`else
        move(CTRL_DN1, 4'd8, 0, 0, 0, 4'd0, 4'd0);
`endif
        move(CTRL_UP1, 4'd7, 0, 0, 0, 4'd0, 4'd0);

        // Seed 15 loads 7
        @(negedge dclk);
        arstn = 1'b0;
        @(negedge dclk);
        arstn = 1'b1;
        start_game(4'd15);
        #2;
        chk("seed15_inval", {4'd0, bus.cnt_inval}, 8'd7);
        move(CTRL_UP1, 4'd7, 0, 0, 0, 4'd0, 4'd0);
        move(CTRL_UP2, 4'd8, 0, 0, 0, 4'd0, 4'd0);

        repeat (5) @(negedge dclk);
        #2;
        chk("pending_events",  8'(evq.size()),  8'd0);
        chk("pending_handshk", 8'(cntq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
